change_dispenser: RTL and testbench

Change-payout unit at the output end of the vending-machine datapath. It receives the change amount the seller FSM reports on `charge_ind`/`charge_val` and pays it out physically. It drives a 1-yuan coin hopper and a 0.5-yuan coin hopper one coin at a time, and confirms each coin with the hopper drop sensor. It reports progress, completion and hopper faults back to the seller/display logic.

---
 rtl/autoseller_pkg.sv | 23 ++
 rtl/change_dispenser_if.sv | 26 ++
 rtl/change_dispenser_cyc_timer.sv | 28 ++
 rtl/change_dispenser.sv | 178 +++++++++++++++++
 tb/tb_change_dispenser.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/autoseller_pkg.sv
// Shared vending-machine types: money width, coin units and the dispenser state encoding.
// Amounts are counted in 0.5-yuan units throughout.
package autoseller_pkg;

    localparam int MONEY_W = 3;

    localparam logic [MONEY_W-1:0] UNIT_1Y  = 3'd2;
    localparam logic [MONEY_W-1:0] UNIT_05Y = 3'd1;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT_SENSE,
        GAP,
        FAULT
    } disp_state_t;

    // Greedy coin choice: the 1-yuan hopper whenever at least one yuan is still owed.
    function automatic logic use_1y(input logic [MONEY_W-1:0] amt);
        return (amt >= UNIT_1Y);
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Seller/display side <-> change dispenser signal bundle.
// master = seller side and sensor, slave = the dispenser itself.
interface change_dispenser_if;
    import autoseller_pkg::*;

    logic               charge_ind;
    logic [MONEY_W-1:0] charge_val;
    logic               coin_sense;
    logic               coin1_drv;
    logic               coin05_drv;
    logic               busy;
    logic [MONEY_W-1:0] remaining;
    logic               done;
    logic               fault;

    modport master (
        output charge_ind, charge_val, coin_sense,
        input  coin1_drv, coin05_drv, busy, remaining, done, fault
    );

    modport slave (
        input  charge_ind, charge_val, coin_sense,
        output coin1_drv, coin05_drv, busy, remaining, done, fault
    );

endinterface

// File: rtl/change_dispenser_cyc_timer.sv
// Loadable down-counter that stops at zero; o_zero flags the terminal count.
// Load wins over decrement.
module cyc_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change payout: drives the 1-yuan / 0.5-yuan hoppers one coin at a time, confirms each
// coin on the drop sensor, retries once per coin and reports done/fault.
module change_dispenser
    import autoseller_pkg::*;
#(
    parameter int PULSE_CYC   = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);

    localparam int TW = 6;
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] ACK_LOAD   = TW'(ACK_TIMEOUT - 1);

    disp_state_t        r_state;
    logic               r_retry;
    logic               r_sensed;
    logic               r_sel_1y;
    logic               r_coin1_drv;
    logic               r_coin05_drv;
    logic               r_busy;
    logic               r_done;
    logic               r_fault;
    logic [MONEY_W-1:0] r_remaining;

    logic               w_pulse_zero;
    logic               w_ack_zero;
    logic               w_req_new;
    logic               w_gap_next;
    logic               w_retry;
    logic               w_pulse_load;
    logic               w_ack_load;
    logic               w_in_drive;
    logic               w_in_wait;
    logic               w_coin_now;
    logic               w_new_1y;
    logic               w_gap_1y;
    logic [MONEY_W-1:0] w_unit;
    logic [MONEY_W-1:0] w_rem_after;

    assign w_in_drive = (r_state == DRIVE);
    assign w_in_wait  = (r_state == WAIT_SENSE);

    // Every transition into DRIVE reloads the pulse-width timer on the same edge.
    assign w_req_new    = ((r_state == IDLE) || (r_state == FAULT))
                          && bus.charge_ind && (bus.charge_val != '0);
    assign w_gap_next   = (r_state == GAP) && (r_remaining != '0);
    assign w_retry      = w_in_wait && !bus.coin_sense && w_ack_zero && !r_retry;
    assign w_pulse_load = w_req_new || w_gap_next || w_retry;
    // Held loaded for the whole pulse so the timeout starts fresh on WAIT_SENSE entry.
    assign w_ack_load   = w_in_drive;

    assign w_coin_now  = r_sensed || bus.coin_sense;
    assign w_new_1y    = use_1y(bus.charge_val);
    assign w_gap_1y    = use_1y(r_remaining);
    assign w_unit      = r_sel_1y ? UNIT_1Y : UNIT_05Y;
    assign w_rem_after = r_remaining - w_unit;

    cyc_timer #(.W(TW)) u_pulse_tmr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pulse_load),
        .i_load_val (PULSE_LOAD),
        .i_en       (w_in_drive),
        .o_zero     (w_pulse_zero)
    );

    cyc_timer #(.W(TW)) u_ack_tmr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_ack_load),
        .i_load_val (ACK_LOAD),
        .i_en       (w_in_wait),
        .o_zero     (w_ack_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_retry      <= 1'b0;
            r_sensed     <= 1'b0;
            r_sel_1y     <= 1'b0;
            r_coin1_drv  <= 1'b0;
            r_coin05_drv <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_remaining  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, FAULT: begin
                    if (bus.charge_ind) begin
                        if (bus.charge_val != '0) begin
                            r_remaining  <= bus.charge_val;
                            r_fault      <= 1'b0;
                            r_retry      <= 1'b0;
                            r_sensed     <= 1'b0;
                            r_sel_1y     <= w_new_1y;
                            r_coin1_drv  <= w_new_1y;
                            r_coin05_drv <= !w_new_1y;
                            r_busy       <= 1'b1;
                            r_state      <= DRIVE;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end

                DRIVE: begin
                    if (bus.coin_sense) begin
                        r_sensed <= 1'b1;
                    end
                    if (w_pulse_zero) begin
                        r_coin1_drv  <= 1'b0;
                        r_coin05_drv <= 1'b0;
                        r_sensed     <= 1'b0;
                        if (w_coin_now) begin
                            r_remaining <= w_rem_after;
                            r_retry     <= 1'b0;
                            r_done      <= (w_rem_after == '0);
                            r_state     <= GAP;
                        end else begin
                            r_state <= WAIT_SENSE;
                        end
                    end
                end

                WAIT_SENSE: begin
                    if (bus.coin_sense) begin
                        r_remaining <= w_rem_after;
                        r_retry     <= 1'b0;
                        r_done      <= (w_rem_after == '0);
                        r_state     <= GAP;
                    end else if (w_ack_zero) begin
                        if (!r_retry) begin
                            r_retry      <= 1'b1;
                            r_coin1_drv  <= r_sel_1y;
                            r_coin05_drv <= !r_sel_1y;
                            r_state      <= DRIVE;
                        end else begin
                            r_busy  <= 1'b0;
                            r_fault <= 1'b1;
                            r_state <= FAULT;
                        end
                    end
                end

                GAP: begin
                    if (r_remaining == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_sel_1y     <= w_gap_1y;
                        r_coin1_drv  <= w_gap_1y;
                        r_coin05_drv <= !w_gap_1y;
                        r_state      <= DRIVE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.coin1_drv  = r_coin1_drv;
    assign bus.coin05_drv = r_coin05_drv;
    assign bus.busy       = r_busy;
    assign bus.remaining  = r_remaining;
    assign bus.done       = r_done;
    assign bus.fault      = r_fault;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a coin-level payout model fills an event queue,
// a monitor pops and compares drive pulses, done pulses and fault entries.
module tb_change_dispenser;
    import autoseller_pkg::*;

    localparam int P = 4;
    localparam int T = 16;

    localparam int EV_D1    = 1;
    localparam int EV_D05   = 2;
    localparam int EV_DONE  = 3;
    localparam int EV_FAULT = 4;

    typedef struct {
        int kind;
        int rem;
        int gap;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    change_dispenser_if dif ();

    change_dispenser #(.PULSE_CYC(P), .ACK_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    ev_t exp_q[$];
    bit  plan_q[$];
    int  errors = 0;
    int  checks = 0;
    bit  mon_en = 0;
    bit  resp_en = 0;
    bit  sense_fixed = 0;
    int  model_fault = 0;
    int  model_rem = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_exp(output ev_t e, output bit got);
        got = 0;
        e = '{0, 0, -1};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: DUT produced an event, none expected (t=%0t)", $time);
        end else begin
            e = exp_q.pop_front();
            got = 1;
        end
    endtask

    // Coin-level model: per attempt decide whether the hopper drops a coin.
    task automatic model_req(input int v, input int mode, input logic [15:0] mask);
        int  rem;
        int  unit;
        int  a;
        bit  ok;
        rem = v;
        a = 0;
        ok = 1;
        if (v == 0) begin
            exp_q.push_back('{EV_DONE, model_rem, -1});
            return;
        end
        model_fault = 0;
        while (rem > 0) begin
            unit = (rem >= 2) ? 2 : 1;
            for (int t = 0; t < 2; t++) begin
                exp_q.push_back('{(unit == 2) ? EV_D1 : EV_D05, rem, (t == 1) ? T : -1});
                ok = (mode == 0) ? !mask[a] : ($urandom_range(0, 3) != 0);
                plan_q.push_back(ok);
                a++;
                if (ok) break;
            end
            if (!ok) begin
                exp_q.push_back('{EV_FAULT, rem, -1});
                model_fault = 1;
                break;
            end
            rem -= unit;
        end
        model_rem = rem;
        if (rem == 0) exp_q.push_back('{EV_DONE, 0, -1});
    endtask

    task automatic run_req(input int v, input int mode, input logic [15:0] mask, input bit noise);
        int n;
        model_req(v, mode, mask);
        @(negedge clk);
        dif.charge_val = v[2:0];
        dif.charge_ind = 1'b1;
        @(negedge clk);
        dif.charge_ind = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
            if (noise && (dif.coin1_drv || dif.coin05_drv) && ($urandom_range(0, 1) == 1)) begin
                dif.charge_val = 3'd7;
                dif.charge_ind = 1'b1;
            end else begin
                dif.charge_ind = 1'b0;
            end
        end
        dif.charge_ind = 1'b0;
        chk("events_outstanding", exp_q.size(), 0);
        exp_q.delete();
        plan_q.delete();
        @(negedge clk);
        chk("busy_after", int'(dif.busy), 0);
        chk("fault_after", int'(dif.fault), model_fault);
        chk("remaining_after", int'(dif.remaining), model_rem);
    endtask

    // Drop sensor: one pulse per successful attempt, inside the drive or within the timeout.
    initial begin : responder
        bit prev;
        bit ok;
        int j;
        int d;
        prev = 0;
        forever begin
            @(negedge clk);
            if (resp_en && (dif.coin1_drv || dif.coin05_drv) && !prev) begin
                ok = (plan_q.size() != 0) ? plan_q.pop_front() : 1'b0;
                if (ok) begin
                    if (!sense_fixed && ($urandom_range(0, 2) == 0)) begin
                        j = $urandom_range(0, P - 1);
                        repeat (j) @(negedge clk);
                    end else begin
                        d = sense_fixed ? 2 : $urandom_range(0, T - 1);
                        repeat (P + d) @(negedge clk);
                    end
                    dif.coin_sense = 1'b1;
                    @(negedge clk);
                    dif.coin_sense = 1'b0;
                end
            end
            prev = dif.coin1_drv || dif.coin05_drv;
        end
    end

    initial begin : monitor
        bit  in_p;
        bit  ovl;
        bit  prev_done;
        bit  prev_fault;
        bit  got;
        int  width;
        int  kind;
        int  start_rem;
        int  idle_cnt;
        int  gap;
        ev_t e;
        in_p = 0; ovl = 0; prev_done = 0; prev_fault = 0;
        width = 0; kind = 0; start_rem = 0; idle_cnt = 0; gap = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                in_p = 0;
                idle_cnt = 0;
            end else begin
                if (dif.coin1_drv || dif.coin05_drv) begin
                    if (!in_p) begin
                        in_p = 1;
                        width = 0;
                        ovl = 0;
                        kind = dif.coin1_drv ? EV_D1 : EV_D05;
                        start_rem = int'(dif.remaining);
                        gap = idle_cnt;
                    end
                    width++;
                    if (dif.coin1_drv && dif.coin05_drv) ovl = 1;
                end else begin
                    if (in_p) begin
                        in_p = 0;
                        idle_cnt = 0;
                        pop_exp(e, got);
                        if (got) begin
                            chk("drive_hopper", kind, e.kind);
                            chk("drive_width", width, P);
                            chk("drive_remaining", start_rem, e.rem);
                            chk("drive_overlap", int'(ovl), 0);
                            if (e.gap >= 0) chk("retry_gap", gap, e.gap);
                        end
                    end
                    idle_cnt++;
                end
                if (dif.done) begin
                    pop_exp(e, got);
                    if (got) begin
                        chk("done_event", EV_DONE, e.kind);
                        chk("done_remaining", int'(dif.remaining), e.rem);
                        chk("done_one_cycle", int'(prev_done), 0);
                    end
                end
                if (dif.fault && !prev_fault) begin
                    pop_exp(e, got);
                    if (got) begin
                        chk("fault_event", EV_FAULT, e.kind);
                        chk("fault_remaining", int'(dif.remaining), e.rem);
                        chk("fault_busy", int'(dif.busy), 0);
                    end
                end
            end
            prev_done = dif.done;
            prev_fault = dif.fault;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        dif.charge_ind = 1'b0;
        dif.charge_val = 3'd0;
        dif.coin_sense = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_coin1_drv", int'(dif.coin1_drv), 0);
        chk("rst_coin05_drv", int'(dif.coin05_drv), 0);
        chk("rst_busy", int'(dif.busy), 0);
        chk("rst_remaining", int'(dif.remaining), 0);
        chk("rst_done", int'(dif.done), 0);
        chk("rst_fault", int'(dif.fault), 0);
        rst = 1'b0;
        mon_en = 1;
        resp_en = 1;

        sense_fixed = 1;
        run_req(5, 0, 16'h0000, 0);
        sense_fixed = 0;
        run_req(0, 0, 16'h0000, 0);
        run_req(2, 0, 16'h0003, 0);
        run_req(1, 0, 16'h0000, 0);
        run_req(3, 0, 16'h0001, 0);
        run_req(4, 0, 16'h0000, 1);

        // Reset in the second cycle of a drive pulse.
        mon_en = 0;
        resp_en = 0;
        @(negedge clk);
        dif.charge_val = 3'd4;
        dif.charge_ind = 1'b1;
        @(negedge clk);
        dif.charge_ind = 1'b0;
        n = 0;
        while (!(dif.coin1_drv || dif.coin05_drv) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_drive_seen", int'(dif.coin1_drv), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_coin1_drv", int'(dif.coin1_drv), 0);
        chk("midrst_coin05_drv", int'(dif.coin05_drv), 0);
        chk("midrst_busy", int'(dif.busy), 0);
        chk("midrst_remaining", int'(dif.remaining), 0);
        chk("midrst_done", int'(dif.done), 0);
        rst = 1'b0;
        model_rem = 0;
        model_fault = 0;
        exp_q.delete();
        plan_q.delete();
        mon_en = 1;
        resp_en = 1;
        run_req(3, 0, 16'h0000, 0);

        for (int i = 0; i < 30; i++) begin
            run_req($urandom_range(0, 7), 1, 16'h0000, bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
